// File: rtl/fft_modulus_calc.sv
// Squared-magnitude stage for FFT bins: three-stage pipeline feeding a
// 73-bit {bin_idx, modulus} FIFO, with frame tracking and length checking.
module fft_modulus_calc #(
  parameter int FRAME_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  output logic        fft_ready,
  input  logic [29:0] fft_re,
  input  logic [29:0] fft_im,
  input  logic        fft_last,
  output logic        fifo_wr_en,
  output logic [72:0] fifo_wr_data,
  input  logic        fifo_almost_full,
  input  logic        fifo_wr_full,
  output logic        frame_done,
  output logic        len_err,
  output logic        drop_err
);

  localparam logic [12:0] LAST_IDX = 13'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [12:0] bin_cnt;
  logic        accept;
  logic        at_end;
  logic        ends;
  logic        mism;

  // The almost-full threshold leaves room for the in-flight beats,
  // so the pipeline never needs to stall.
  assign fft_ready = !fifo_almost_full;
  assign accept    = fft_valid && fft_ready;
  assign at_end    = (bin_cnt == LAST_IDX);
  assign ends      = fft_last || at_end;
  // A single-beat frame from IDLE is a legal short frame, not an error.
  assign mism      = (state == ACTIVE) && (fft_last != at_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_cnt <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (!fft_last) begin
            state   <= ACTIVE;
            bin_cnt <= 13'd1;
          end
        end
        ACTIVE: begin
          if (ends) begin
            state   <= IDLE;
            bin_cnt <= '0;
          end else begin
            bin_cnt <= bin_cnt + 13'd1;
          end
        end
      endcase
    end
  end

  logic               s1_valid;
  logic signed [29:0] s1_re;
  logic signed [29:0] s1_im;
  logic [12:0]        s1_idx;
  logic               s1_end;
  logic               s1_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_idx   <= '0;
      s1_end   <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_re    <= fft_re;
      s1_im    <= fft_im;
      s1_idx   <= bin_cnt;
      s1_end   <= ends;
      s1_err   <= mism;
    end
  end

  logic signed [59:0] p_re;
  logic signed [59:0] p_im;

  assign p_re = s1_re * s1_re;
  assign p_im = s1_im * s1_im;

  logic        s2_valid;
  logic [58:0] s2_sq_re;
  logic [58:0] s2_sq_im;
  logic [12:0] s2_idx;
  logic        s2_end;
  logic        s2_err;

  // A square of a 30-bit value never exceeds 2^58, so 59 bits hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sq_re <= '0;
      s2_sq_im <= '0;
      s2_idx   <= '0;
      s2_end   <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_sq_re <= 59'(p_re);
      s2_sq_im <= 59'(p_im);
      s2_idx   <= s1_idx;
      s2_end   <= s1_end;
      s2_err   <= s1_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_done   <= 1'b0;
      len_err      <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      fifo_wr_en <= s2_valid;
      frame_done <= s2_valid && s2_end;
      len_err    <= s2_valid && s2_err;
      if (s2_valid) begin
        fifo_wr_data <= {s2_idx,
                         {1'b0, s2_sq_re} + {1'b0, s2_sq_im}};
      end
      if (fifo_wr_en && fifo_wr_full) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fft_modulus_calc.md
FFT_MODULUS_CALC -- requirements
Module: fft_modulus_calc

Interface
REQ-001 Parameter FRAME_LEN, default 1024, number of FFT bins per frame; legal range 2..8192.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset; reset is synchronous and active-high.
REQ-004 fft_valid  input  1  FFT output beat valid.
REQ-005 fft_ready  output  1  block accepts a beat when fft_valid and fft_ready are both 1.
REQ-006 fft_re  input  30  real part, signed two's complement.
REQ-007 fft_im  input  30  imaginary part, signed two's complement.
REQ-008 fft_last  input  1  marks the final bin of a frame.
REQ-009 fifo_wr_en  output  1  write strobe to the downstream 73-bit modulus FIFO.
REQ-010 fifo_wr_data  output  73  packed word {bin_idx[12:0], modulus[59:0]}.
REQ-011 fifo_almost_full  input  1  FIFO almost-full flag (threshold 1020 words).
REQ-012 fifo_wr_full  input  1  FIFO full flag.
REQ-013 frame_done  output  1  one-cycle pulse coincident with the FIFO write of the last bin.
REQ-014 len_err  output  1  one-cycle pulse on a frame-length mismatch.
REQ-015 drop_err  output  1  sticky flag: a word was written while the FIFO was full.

Function
REQ-016 The block SHALL compute modulus = re*re + im*im as an unsigned 60-bit value, with no truncation or saturation; the maximum value is 2^59 at re = im = -2^29.
REQ-017 Pipeline, 3 stages:
- S1: register re, im, bin index and last.
- S2: register both 59-bit squares.
- S3: register the sum into fifo_wr_data and set fifo_wr_en.
REQ-018 A beat accepted in cycle T SHALL produce fifo_wr_en=1 in cycle T+3, with its data; accepted beats SHALL never be dropped, reordered or duplicated.
REQ-019 fft_ready SHALL equal !fifo_almost_full, registered-free (combinational); the pipeline itself never stalls.
- Rationale: almost_full leaves at least 3 words of slack for in-flight beats.
REQ-020 bin_idx SHALL be 0 for the first accepted beat after reset or after a frame end, and increment by 1 per accepted beat.
REQ-021 Frame FSM states:
- IDLE: bin counter is 0; the first accepted beat moves to ACTIVE.
- ACTIVE: an accepted beat with fft_last=1, or with bin counter = FRAME_LEN-1, returns to IDLE and clears the counter.
- A single-beat frame goes IDLE->IDLE.
REQ-022 fft_last accepted with bin counter != FRAME_LEN-1: len_err pulses at T+3; the counter restarts at 0.
REQ-023 Bin counter reaches FRAME_LEN-1 with fft_last=0: len_err pulses at T+3; the counter wraps to 0.
REQ-024 frame_done SHALL pulse at T+3 for every beat that ends a frame per REQ-021, including error-terminated frames.
REQ-025 If fifo_wr_en=1 while fifo_wr_full=1:
- the word is still presented;
- drop_err SHALL set and hold until rst.
REQ-026 Beats with fft_valid=1 and fft_ready=0 SHALL not be accepted, not counted and not advance the FSM.

Reset
REQ-027 On rst=1 at a clk edge, the following SHALL be 0 on the next cycle: fifo_wr_en, fifo_wr_data, frame_done, len_err, drop_err, the bin counter and all pipeline valid bits; the FSM SHALL be in IDLE.
REQ-028 rst mid-frame SHALL discard all in-flight pipeline beats, with no FIFO write after the reset cycle; the next accepted beat SHALL have bin_idx 0.
REQ-029 fft_ready during rst SHALL still follow REQ-019; beats presented in the rst cycle are discarded.

Verification
REQ-030 Single beat re=3, im=-4, last=1, FRAME_LEN=4 -> 3 cycles later: wr_en=1, data={13'd0, 60'd25}, frame_done=1, len_err=0.
REQ-031 re=im=-2^29 -> modulus = 2^59 exactly; re=im=2^29-1 -> modulus = 2*(2^29-1)^2.
REQ-032 FRAME_LEN=4, 4 back-to-back beats, last on the 4th -> indices 0,1,2,3 on consecutive cycles; frame_done only with index 3; a following frame starts at 0.
REQ-033 FRAME_LEN=4, last on the 2nd beat -> len_err pulse with index 1; the next beat has index 0. Six beats with no last -> len_err and frame_done with index 3, wrap to 0.
REQ-034 almost_full driven high mid-stream -> fft_ready=0 in the same cycle; the 3 in-flight words still write; no gaps or duplicates in bin indices after release.
REQ-035 fifo_wr_full=1 during a write -> drop_err=1 and held; rst asserted mid-frame -> no wr_en after reset, drop_err=0, next index 0.
